stopwatch_run_ctrl: RTL and testbench

//  Run/pause/clear/lap sequencer for the seven-segment seconds counter datapath.

---
 rtl/stopwatch_run_ctrl.sv | 97 +++++++++
 tb/tb_stopwatch_run_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_run_ctrl.sv
// stopwatch_run_ctrl: run/pause/clear/lap sequencer with prescaled seconds tick and lap freeze
module stopwatch_run_ctrl #(
  parameter int CLK_HZ    = 10_000_000,
  parameter int COUNT_MAX = 9,
  parameter int CMP_W     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             btn_startstop,
  input  logic             btn_clear,
  input  logic             btn_lap,
  input  logic             cmp_load,
  input  logic [CMP_W-1:0] cmp_value,
  output logic [3:0]       digit,
  output logic             running,
  output logic             lap_active,
  output logic             tick,
  output logic             wrap
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2;
  localparam logic [CMP_W-1:0] CMP_RST = CMP_W'(CLK_HZ - 1);
  localparam logic [3:0] CMAX = 4'(COUNT_MAX);
  logic [1:0] state;
  logic [2:0] s1, s2, s3, rise;
  logic [CMP_W-1:0] pre, cmp;
  logic [3:0] count, lap_val;
  logic tick_r, wrap_r, p_clr, p_ss, p_lap, hit;
  // bit 0 startstop, bit 1 clear, bit 2 lap; clear outranks startstop outranks lap
  always_comb begin
    rise = s2 & ~s3;
    p_clr = rise[1];
    p_ss = rise[0] & ~rise[1];
    p_lap = rise[2] & ~rise[1] & ~rise[0];
    hit = pre == cmp;
  end
  assign digit = lap_active ? lap_val : count;
  assign running = state == RUN;
  assign tick = tick_r & ena;
  assign wrap = wrap_r & ena;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      pre <= '0;
      cmp <= CMP_RST;
      count <= '0;
      lap_val <= '0;
      lap_active <= 1'b0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else if (!ena) begin
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      s1 <= {btn_lap, btn_clear, btn_startstop};
      s2 <= s1;
      s3 <= s2;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
      case (state)
        IDLE: begin
          if (cmp_load) cmp <= cmp_value;
          if (p_ss) state <= RUN;
        end
        RUN: begin
          // leaving RUN suppresses any tick due this cycle and keeps the prescaler
          if (p_ss) state <= PAUSE;
          else begin
            pre <= hit ? '0 : pre + 1'b1;
            if (hit) begin
              count <= count == CMAX ? 4'd0 : count + 4'd1;
              tick_r <= 1'b1;
              wrap_r <= count == CMAX;
            end
            if (p_lap) begin
              if (!lap_active) lap_val <= count;
              lap_active <= !lap_active;
            end
          end
        end
        PAUSE: begin
          if (p_clr) begin
            state <= IDLE;
            count <= '0;
            pre <= '0;
            lap_active <= 1'b0;
          end else if (p_ss) state <= RUN;
          else if (p_lap) lap_active <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// tb_stopwatch_run_ctrl: directed stimulus with a tick-event scoreboard and status checks
module tb_stopwatch_run_ctrl;
  localparam logic [2:0] SS = 3'b001, CLR = 3'b010, LAP = 3'b100;
  logic clk = 1'b0;
  logic rst, ena, btn_startstop, btn_clear, btn_lap, cmp_load;
  logic [23:0] cmp_value;
  logic [3:0] digit;
  logic running, lap_active, tick, wrap;
  typedef struct {
    int cyc;
    logic [3:0] d;
    logic w;
  } ev_t;
  ev_t q[$];
  int total = 0, bad = 0, cyc = 0;
  stopwatch_run_ctrl #(.CLK_HZ(5), .COUNT_MAX(9), .CMP_W(24)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .btn_startstop(btn_startstop), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .cmp_load(cmp_load), .cmp_value(cmp_value),
    .digit(digit), .running(running), .lap_active(lap_active), .tick(tick), .wrap(wrap)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: every tick/wrap cycle must match the oldest expected event
  always @(negedge clk) begin : mon
    ev_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_tick: no tick seen at cycle %0d (now %0d)", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (tick || wrap) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL stray_tick: cycle %0d tick=%0b wrap=%0b digit=%0d, none expected", cyc, tick, wrap, digit);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.d != digit || e.w != wrap || !tick) begin
          bad++;
          $display("FAIL tick_event: got cyc=%0d tick=%0b digit=%0d wrap=%0b, expected cyc=%0d tick=1 digit=%0d wrap=%0b",
                   cyc, tick, digit, wrap, e.cyc, e.d, e.w);
        end
      end
    end
  end
  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask
  task automatic push(input int c, input int d, input logic w);
    ev_t e;
    e.cyc = c;
    e.d = 4'(d);
    e.w = w;
    q.push_back(e);
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // raises buttons in m for len cycles; eff is the edge at which the press acts
  task automatic press(input logic [2:0] m, input int len, output int eff);
    int c0;
    c0 = cyc;
    {btn_lap, btn_clear, btn_startstop} = m;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
    {btn_lap, btn_clear, btn_startstop} = 3'b000;
    eff = c0 + 3;
    wait_cyc(eff);
  endtask
  task automatic load(input logic [23:0] v);
    cmp_value = v;
    cmp_load = 1'b1;
    @(posedge clk);
    #1;
    cmp_load = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int r, e;
    rst = 1'b1;
    ena = 1'b1;
    {btn_lap, btn_clear, btn_startstop} = 3'b000;
    cmp_load = 1'b0;
    cmp_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digit", digit, 0);
    chk("rst_running", running, 0);
    chk("rst_lap", lap_active, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // count 0..9 then wrap, period 5
    press(SS, 1, r);
    chk("t1_running", running, 1);
    for (int k = 1; k <= 11; k++) push(r + 5 * k, k % 10, (k % 10) == 0);
    wait_cyc(r + 56);
    press(SS, 1, e);
    chk("t1_pause_running", running, 0);
    chk("t1_pause_digit", digit, 1);
    press(CLR, 1, e);
    chk("t1_clr_running", running, 0);
    chk("t1_clr_digit", digit, 0);
    // compare 2 loaded in IDLE, later load in RUN ignored
    load(24'd2);
    press(SS, 1, r);
    load(24'd7);
    for (int k = 1; k <= 4; k++) push(r + 3 * k, k, 1'b0);
    wait_cyc(r + 12);
    press(SS, 1, e);
    chk("t2_pause_on_due_tick", running, 0);
    chk("t2_pause_digit", digit, 4);
    push(r + 19, 5, 1'b0);
    press(SS, 1, e);
    wait_cyc(r + 19);
    press(SS, 1, e);
    chk("t2_pause2_digit", digit, 5);
    press(CLR, 1, e);
    chk("t2_clr_digit", digit, 0);
    // pause with prescaler at 2, resume from there
    load(24'd4);
    press(SS, 1, r);
    press(SS, 1, e);
    chk("t3_paused", running, 0);
    wait_cyc(r + 13);
    chk("t3_pause_digit", digit, 0);
    press(SS, 1, r);
    for (int k = 1; k <= 3; k++) push(r + 3 + 5 * (k - 1), k, 1'b0);
    wait_cyc(r + 13);
    // lap freeze at 3 while count climbs to 6
    press(LAP, 1, e);
    chk("t4_lap_active", lap_active, 1);
    chk("t4_lap_digit", digit, 3);
    push(r + 18, 3, 1'b0);
    push(r + 23, 3, 1'b0);
    push(r + 28, 3, 1'b0);
    wait_cyc(r + 28);
    press(LAP, 1, e);
    chk("t4_unlap_active", lap_active, 0);
    chk("t4_unlap_digit", digit, 6);
    push(r + 33, 7, 1'b0);
    wait_cyc(r + 35);
    push(r + 38, 7, 1'b0);
    press(LAP, 1, e);
    chk("t4_lap_on_tick_active", lap_active, 1);
    chk("t4_lap_on_tick_digit", digit, 7);
    // clear ignored in RUN, then clear+startstop in PAUSE
    push(r + 43, 7, 1'b0);
    press(CLR, 1, e);
    chk("t5_clr_run_running", running, 1);
    chk("t5_clr_run_digit", digit, 7);
    chk("t5_clr_run_lap", lap_active, 1);
    press(SS, 1, e);
    chk("t5_pause", running, 0);
    press(CLR | SS, 1, e);
    chk("t5_both_running", running, 0);
    chk("t5_both_digit", digit, 0);
    chk("t5_both_lap", lap_active, 0);
    // held start gives one press; ena low freezes everything
    press(SS, 5, r);
    chk("t6_held_running", running, 1);
    push(r + 5, 1, 1'b0);
    push(r + 30, 2, 1'b0);
    wait_cyc(r + 7);
    ena = 1'b0;
    wait_cyc(r + 17);
    chk("t6_frozen_digit", digit, 1);
    chk("t6_frozen_running", running, 1);
    chk("t6_frozen_tick", tick, 0);
    wait_cyc(r + 27);
    ena = 1'b1;
    wait_cyc(r + 31);
    rst = 1'b1;
    ena = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_digit", digit, 0);
    chk("t6_rst_running", running, 0);
    chk("t6_rst_lap", lap_active, 0);
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_wrap", wrap, 0);
    rst = 1'b0;
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pending_ticks", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
